rsa_seq_ctrl: RTL and testbench

Sequencer for the RSA systolic array. It takes one matrix-multiply command and streams the X and Y operands from two synchronous operand buffers into RSA's Xin/Yin ports. It then collects the X*Y results from RSA's out_val/out_data stream, tags each with an index and signals completion. It sits between the operand buffers or host command path and the RSA instance.

---
 rtl/rsa_ctrl_pkg.sv | 47 ++++
 rtl/rsa_feed_gen.sv | 110 +++++++++++
 rtl/rsa_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_rsa_seq_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsa_ctrl_pkg
// Description : Shared types and sizing helpers for the RSA sequencer
//               (FSM state encoding, feed/result lengths, width helper).
// Revision    : 1.0 - initial release
// ============================================================================
package rsa_ctrl_pkg;

    // Sequencer states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Default array geometry
    localparam int C_X_DEF = 3;
    localparam int C_N_DEF = 3;
    localparam int C_Y_DEF = 3;

    // Number of feed beats: the longer operand sets the feed length
    function automatic int fn_feed_len(input int x, input int n, input int y);
        return ((x > y) ? x : y) * n;
    endfunction

    // Number of results produced by one multiply
    function automatic int fn_res_num(input int x, input int y);
        return x * y;
    endfunction

    // Bits needed to hold the value v itself (minimum 1)
    function automatic int fn_width(input int v);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if (v >= (1 << i)) w = i + 1;
        end
        return w;
    endfunction

    localparam int FEED_LEN = fn_feed_len(C_X_DEF, C_N_DEF, C_Y_DEF);
    localparam int RES_NUM  = fn_res_num(C_X_DEF, C_Y_DEF);

endpackage
`default_nettype wire

// File: rtl/rsa_feed_gen.sv
`default_nettype none
// ============================================================================
// Module      : rsa_feed_gen
// Description : Feed counter, X/Y operand buffer address generation, read
//               enables and one-cycle valid/data alignment toward the RSA.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_feed_gen
    import rsa_ctrl_pkg::*;
#(
    parameter int X      = 3,
    parameter int N      = 3,
    parameter int Y      = 3,
    parameter int IN_LEN = 4,
    parameter int BUF_AW = 4
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              load,
    input  logic              active,
    input  logic [BUF_AW-1:0] base_x,
    input  logic [BUF_AW-1:0] base_y,
    output logic              last,
    output logic              pipe_busy,
    output logic              xbuf_rd_en,
    output logic [BUF_AW-1:0] xbuf_rd_addr,
    input  logic [IN_LEN-1:0] xbuf_rd_data,
    output logic              ybuf_rd_en,
    output logic [BUF_AW-1:0] ybuf_rd_addr,
    input  logic [IN_LEN-1:0] ybuf_rd_data,
    output logic              Xin_val,
    output logic [IN_LEN-1:0] Xin_data,
    output logic              Yin_val,
    output logic [IN_LEN-1:0] Yin_data
);

    localparam int C_FEED_LEN = fn_feed_len(X, N, Y);
    localparam int C_X_LEN    = X * N;
    localparam int C_Y_LEN    = Y * N;
    localparam int C_CW       = fn_width(C_FEED_LEN);

    logic [C_CW-1:0]   r_cnt;
    logic [BUF_AW-1:0] r_base_x;
    logic [BUF_AW-1:0] r_base_y;
    logic              r_x_rd_en;
    logic              r_y_rd_en;
    logic [BUF_AW-1:0] r_x_addr;
    logic [BUF_AW-1:0] r_y_addr;
    logic              r_xin_val;
    logic              r_yin_val;
    logic              w_x_req;
    logic              w_y_req;

    assign last    = active && (r_cnt == C_CW'(C_FEED_LEN - 1));
    assign w_x_req = active && (r_cnt < C_CW'(C_X_LEN));
    assign w_y_req = active && (r_cnt < C_CW'(C_Y_LEN));

    // Feed counter and base latch: cleared/captured at command accept
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt    <= '0;
            r_base_x <= '0;
            r_base_y <= '0;
        end else if (load) begin
            r_cnt    <= '0;
            r_base_x <= base_x;
            r_base_y <= base_y;
        end else if (active && !last) begin
            r_cnt <= r_cnt + C_CW'(1);
        end
    end

    // Registered read requests; addresses wrap naturally at 2**BUF_AW
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_x_rd_en <= 1'b0;
            r_y_rd_en <= 1'b0;
            r_x_addr  <= '0;
            r_y_addr  <= '0;
        end else begin
            r_x_rd_en <= w_x_req;
            r_y_rd_en <= w_y_req;
            if (w_x_req) r_x_addr <= r_base_x + BUF_AW'(r_cnt);
            if (w_y_req) r_y_addr <= r_base_y + BUF_AW'(r_cnt);
        end
    end

    // Valids trail the read enables by the buffer's one-cycle read latency
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_xin_val <= 1'b0;
            r_yin_val <= 1'b0;
        end else begin
            r_xin_val <= r_x_rd_en;
            r_yin_val <= r_y_rd_en;
        end
    end

    assign xbuf_rd_en   = r_x_rd_en;
    assign xbuf_rd_addr = r_x_addr;
    assign ybuf_rd_en   = r_y_rd_en;
    assign ybuf_rd_addr = r_y_addr;
    assign Xin_val      = r_xin_val;
    assign Yin_val      = r_yin_val;
    assign Xin_data     = r_xin_val ? xbuf_rd_data : '0;
    assign Yin_data     = r_yin_val ? ybuf_rd_data : '0;
    assign pipe_busy    = r_x_rd_en | r_y_rd_en | r_xin_val | r_yin_val;

endmodule
`default_nettype wire

// File: rtl/rsa_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rsa_seq_ctrl
// Description : Command sequencer for the RSA systolic array: streams X/Y
//               operands from the operand buffers, collects and indexes the
//               results, and pulses done on completion.
//               Optional macro RSA_CTRL_PERF_EN adds a perf_cycles counter.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_seq_ctrl
    import rsa_ctrl_pkg::*;
#(
    parameter int X       = 3,
    parameter int N       = 3,
    parameter int Y       = 3,
    parameter int IN_LEN  = 4,
    parameter int OUT_LEN = 8,
    parameter int BUF_AW  = 4,
    parameter int RES_AW  = 4
) (
    input  logic               clk,
    input  logic               sys_rst_n,
    input  logic               start_val,
    output logic               start_rdy,
    input  logic [BUF_AW-1:0]  base_x,
    input  logic [BUF_AW-1:0]  base_y,
    output logic               xbuf_rd_en,
    output logic [BUF_AW-1:0]  xbuf_rd_addr,
    input  logic [IN_LEN-1:0]  xbuf_rd_data,
    output logic               ybuf_rd_en,
    output logic [BUF_AW-1:0]  ybuf_rd_addr,
    input  logic [IN_LEN-1:0]  ybuf_rd_data,
    output logic               Xin_val,
    output logic [IN_LEN-1:0]  Xin_data,
    output logic               Yin_val,
    output logic [IN_LEN-1:0]  Yin_data,
    input  logic               out_val,
    input  logic [OUT_LEN-1:0] out_data,
    output logic               res_val,
    output logic [OUT_LEN-1:0] res_data,
    output logic [RES_AW-1:0]  res_idx,
    output logic               busy,
    output logic               done,
    output logic               stray_err
`ifdef RSA_CTRL_PERF_EN
    ,
    output logic [15:0]        perf_cycles
`endif
);

    localparam int C_RES_NUM = fn_res_num(X, Y);
    localparam int C_RCW     = fn_width(C_RES_NUM);

    state_t             r_state;
    logic [C_RCW-1:0]   r_res_cnt;
    logic               r_res_val;
    logic [OUT_LEN-1:0] r_res_data;
    logic [RES_AW-1:0]  r_res_idx;
    logic               r_stray;
    logic               w_accept;
    logic               w_feed_last;
    logic               w_pipe_busy;
    logic               w_res_all;
    logic               w_window;
    logic               w_res_take;
    logic               w_stray;

    assign start_rdy  = (r_state == ST_IDLE);
    assign busy       = (r_state == ST_FEED) || (r_state == ST_DRAIN);
    assign done       = (r_state == ST_DONE);
    assign w_accept   = start_val && start_rdy;
    assign w_window   = busy;
    assign w_res_all  = (r_res_cnt == C_RCW'(C_RES_NUM));
    assign w_res_take = w_window && out_val && !w_res_all;
    assign w_stray    = out_val && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    rsa_feed_gen #(
        .X      (X),
        .N      (N),
        .Y      (Y),
        .IN_LEN (IN_LEN),
        .BUF_AW (BUF_AW)
    ) u_feed (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .load         (w_accept),
        .active       (r_state == ST_FEED),
        .base_x       (base_x),
        .base_y       (base_y),
        .last         (w_feed_last),
        .pipe_busy    (w_pipe_busy),
        .xbuf_rd_en   (xbuf_rd_en),
        .xbuf_rd_addr (xbuf_rd_addr),
        .xbuf_rd_data (xbuf_rd_data),
        .ybuf_rd_en   (ybuf_rd_en),
        .ybuf_rd_addr (ybuf_rd_addr),
        .ybuf_rd_data (ybuf_rd_data),
        .Xin_val      (Xin_val),
        .Xin_data     (Xin_data),
        .Yin_val      (Yin_val),
        .Yin_data     (Yin_data)
    );

    // Command FSM: DRAIN waits for every result and an empty operand pipe
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_accept) r_state <= ST_FEED;
                ST_FEED:  if (w_feed_last) r_state <= w_res_all ? ST_DONE : ST_DRAIN;
                ST_DRAIN: if (w_res_all && !w_pipe_busy) r_state <= ST_DONE;
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Result capture: register and index results, dropping any beyond X*Y
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_res_cnt  <= '0;
            r_res_val  <= 1'b0;
            r_res_data <= '0;
            r_res_idx  <= '0;
        end else begin
            r_res_val <= w_res_take;
            if (w_accept) begin
                r_res_cnt <= '0;
            end else if (w_res_take) begin
                r_res_cnt <= r_res_cnt + C_RCW'(1);
            end
            if (w_res_take) begin
                r_res_data <= out_data;
                r_res_idx  <= RES_AW'(r_res_cnt);
            end
        end
    end

    // Sticky stray-result flag, cleared when the next command is accepted
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_stray <= 1'b0;
        end else begin
            r_stray <= (w_accept ? 1'b0 : r_stray) | w_stray;
        end
    end

    assign res_val   = r_res_val;
    assign res_data  = r_res_data;
    assign res_idx   = r_res_idx;
    assign stray_err = r_stray;

`ifdef RSA_CTRL_PERF_EN
    logic [15:0] r_perf;

    // Busy-cycle counter, saturating, held after done until next accept
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_perf <= 16'd0;
        end else if (w_accept) begin
            r_perf <= 16'd0;
        end else if (busy && (r_perf != 16'hFFFF)) begin
            r_perf <= r_perf + 16'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rsa_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsa_seq_ctrl
// Description : Scoreboard bench for rsa_seq_ctrl. Stimulus pushes expected
//               addresses, operand beats, results and done events into
//               queues; a negedge monitor pops and compares.
//               Honours RSA_CTRL_PERF_EN for the perf_cycles port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsa_seq_ctrl;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic        start_val;
    logic        start_rdy;
    logic [3:0]  base_x;
    logic [3:0]  base_y;
    logic        xbuf_rd_en;
    logic [3:0]  xbuf_rd_addr;
    logic [3:0]  xbuf_rd_data = 4'd0;
    logic        ybuf_rd_en;
    logic [3:0]  ybuf_rd_addr;
    logic [3:0]  ybuf_rd_data = 4'd0;
    logic        Xin_val;
    logic [3:0]  Xin_data;
    logic        Yin_val;
    logic [3:0]  Yin_data;
    logic        out_val;
    logic [7:0]  out_data;
    logic        res_val;
    logic [7:0]  res_data;
    logic [3:0]  res_idx;
    logic        busy;
    logic        done;
    logic        stray_err;
`ifdef RSA_CTRL_PERF_EN
    logic [15:0] perf_cycles;
`endif

    always #5 clk = ~clk;

    rsa_seq_ctrl dut (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .start_val    (start_val),
        .start_rdy    (start_rdy),
        .base_x       (base_x),
        .base_y       (base_y),
        .xbuf_rd_en   (xbuf_rd_en),
        .xbuf_rd_addr (xbuf_rd_addr),
        .xbuf_rd_data (xbuf_rd_data),
        .ybuf_rd_en   (ybuf_rd_en),
        .ybuf_rd_addr (ybuf_rd_addr),
        .ybuf_rd_data (ybuf_rd_data),
        .Xin_val      (Xin_val),
        .Xin_data     (Xin_data),
        .Yin_val      (Yin_val),
        .Yin_data     (Yin_data),
        .out_val      (out_val),
        .out_data     (out_data),
        .res_val      (res_val),
        .res_data     (res_data),
        .res_idx      (res_idx),
        .busy         (busy),
        .done         (done),
        .stray_err    (stray_err)
`ifdef RSA_CTRL_PERF_EN
        ,
        .perf_cycles  (perf_cycles)
`endif
    );

    // Operand buffer models: synchronous read, one-cycle latency
    logic [3:0] xmem [16];
    logic [3:0] ymem [16];
    always @(posedge clk) begin
        if (xbuf_rd_en) xbuf_rd_data <= xmem[xbuf_rd_addr];
        if (ybuf_rd_en) ybuf_rd_data <= ymem[ybuf_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int aux;
        int cyc;
    } ev_t;

    ev_t qxa[$];
    ev_t qya[$];
    ev_t qxd[$];
    ev_t qyd[$];
    ev_t qres[$];
    ev_t qdone[$];

    int n_total = 0;
    int n_pass  = 0;
    int cur_acc = 0;
    int last_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event
    ev_t m;
    always @(negedge clk) begin
        if (sys_rst_n === 1'b1) begin
            if (xbuf_rd_en) begin
                if (qxa.size() == 0) chk("xaddr_extra", 1, 0);
                else begin
                    m = qxa.pop_front();
                    chk("xaddr", 32'(xbuf_rd_addr), m.val);
                    chk("xaddr_cyc", cyc, m.cyc);
                end
            end
            if (ybuf_rd_en) begin
                if (qya.size() == 0) chk("yaddr_extra", 1, 0);
                else begin
                    m = qya.pop_front();
                    chk("yaddr", 32'(ybuf_rd_addr), m.val);
                    chk("yaddr_cyc", cyc, m.cyc);
                end
            end
            if (Xin_val) begin
                if (qxd.size() == 0) chk("xin_extra", 1, 0);
                else begin
                    m = qxd.pop_front();
                    chk("xin_data", 32'(Xin_data), m.val);
                    chk("xin_cyc", cyc, m.cyc);
                end
            end else begin
                if (Xin_data !== 4'd0) chk("xin_idle_data", 32'(Xin_data), 0);
            end
            if (Yin_val) begin
                if (qyd.size() == 0) chk("yin_extra", 1, 0);
                else begin
                    m = qyd.pop_front();
                    chk("yin_data", 32'(Yin_data), m.val);
                    chk("yin_cyc", cyc, m.cyc);
                end
            end
            if (res_val) begin
                if (qres.size() == 0) chk("res_extra", 1, 0);
                else begin
                    m = qres.pop_front();
                    chk("res_data", 32'(res_data), m.val);
                    chk("res_idx", 32'(res_idx), m.aux);
                    chk("res_cyc", cyc, m.cyc);
                end
            end
            if (done) begin
                if (qdone.size() == 0) chk("done_extra", 1, 0);
                else begin
                    m = qdone.pop_front();
                    chk("done_cyc", cyc, m.cyc);
                    chk("busy_at_done", 32'(busy), 0);
`ifdef RSA_CTRL_PERF_EN
                    chk("perf_cycles", 32'(perf_cycles), m.val);
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected feed for a command accepted at edge acc
    task automatic push_feed(input int acc, input logic [3:0] bx, input logic [3:0] by,
                             input int nrd, input int nval);
        ev_t e;
        logic [3:0] a;
        for (int i = 0; i < nrd; i++) begin
            e.aux = 0;
            a = bx + 4'(i); e.val = int'(a); e.cyc = acc + 1 + i; qxa.push_back(e);
            a = by + 4'(i); e.val = int'(a); e.cyc = acc + 1 + i; qya.push_back(e);
        end
        for (int i = 0; i < nval; i++) begin
            e.aux = 0;
            a = bx + 4'(i); e.val = int'(xmem[a]); e.cyc = acc + 2 + i; qxd.push_back(e);
            a = by + 4'(i); e.val = int'(ymem[a]); e.cyc = acc + 2 + i; qyd.push_back(e);
        end
    endtask

    task automatic issue(input logic [3:0] bx, input logic [3:0] by, input bit hold,
                         input int nrd, input int nval);
        int n;
        n = 0;
        while (!start_rdy && n < 50) begin
            tick();
            n++;
        end
        chk("start_rdy_before_accept", 32'(start_rdy), 1);
        start_val = 1'b1;
        base_x    = bx;
        base_y    = by;
        cur_acc   = cyc + 1;
        push_feed(cur_acc, bx, by, nrd, nval);
        tick();
        if (!hold) start_val = 1'b0;
    endtask

    // Nine results after the feed has drained; done expected one cycle after
    // the last res_val, perf equal to the accept-to-done busy cycles
    task automatic inject(input int d0);
        ev_t e;
        while (cyc < cur_acc + 11) tick();
        for (int i = 0; i < 9; i++) begin
            out_val  = 1'b1;
            out_data = 8'(d0 + i);
            e.val = (d0 + i) & 255;
            e.aux = i;
            e.cyc = cyc + 1;
            qres.push_back(e);
            tick();
        end
        out_val   = 1'b0;
        last_done = cyc + 1;
        e.val = last_done - cur_acc;
        e.aux = 0;
        e.cyc = last_done;
        qdone.push_back(e);
        while (cyc < last_done + 1) tick();
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            xmem[i] = 4'(i * 3 + 1);
            ymem[i] = 4'(15 - i);
        end
        sys_rst_n = 1'b0;
        start_val = 1'b0;
        base_x    = 4'd0;
        base_y    = 4'd0;
        out_val   = 1'b0;
        out_data  = 8'd0;
        repeat (3) tick();

        // Reset state
        chk("rst_start_rdy", 32'(start_rdy), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_xrd", 32'(xbuf_rd_en), 0);
        chk("rst_xin", 32'(Xin_val), 0);
        chk("rst_res_val", 32'(res_val), 0);
        chk("rst_stray", 32'(stray_err), 0);
        sys_rst_n = 1'b1;
        tick();

        // Basic command at base 0/0
        issue(4'd0, 4'd0, 1'b0, 9, 9);
        chk("busy_after_accept", 32'(busy), 1);
        chk("start_rdy_busy", 32'(start_rdy), 0);
        inject(8'h10);

        // X base wraps at 2**BUF_AW
        issue(4'd14, 4'd0, 1'b0, 9, 9);
        inject(8'h50);

        // start_val held through the command: single accept, next only after done
        issue(4'd1, 4'd2, 1'b1, 9, 9);
        tick();
        tick();
        chk("start_rdy_held", 32'(start_rdy), 0);
        chk("busy_held", 32'(busy), 1);
        inject(8'h20);
        chk("start_rdy_after_done", 32'(start_rdy), 1);
        cur_acc = last_done + 2;
        push_feed(cur_acc, 4'd1, 4'd2, 9, 9);
        while (cyc < cur_acc) tick();
        start_val = 1'b0;
        chk("busy_second_accept", 32'(busy), 1);
        inject(8'h30);

        // Stray result while idle
        out_val  = 1'b1;
        out_data = 8'hEE;
        tick();
        out_val = 1'b0;
        chk("stray_set", 32'(stray_err), 1);
        chk("stray_no_res", 32'(res_val), 0);
        tick();
        chk("stray_sticky", 32'(stray_err), 1);
        issue(4'd3, 4'd5, 1'b0, 4, 3);
        chk("stray_cleared", 32'(stray_err), 0);

        // Asynchronous reset in the middle of the feed
        while (cyc < cur_acc + 5) tick();
        sys_rst_n = 1'b0;
        #2;
        chk("mid_rst_start_rdy", 32'(start_rdy), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_xrd", 32'(xbuf_rd_en), 0);
        chk("mid_rst_yrd", 32'(ybuf_rd_en), 0);
        chk("mid_rst_xin", 32'(Xin_val), 0);
        chk("mid_rst_done", 32'(done), 0);
`ifdef RSA_CTRL_PERF_EN
        chk("mid_rst_perf", 32'(perf_cycles), 0);
`endif
        tick();
        tick();
        sys_rst_n = 1'b1;
        tick();
        issue(4'd7, 4'd9, 1'b0, 9, 9);
        inject(8'h40);

        repeat (5) tick();
        chk("q_xaddr_empty", qxa.size(), 0);
        chk("q_yaddr_empty", qya.size(), 0);
        chk("q_xin_empty", qxd.size(), 0);
        chk("q_yin_empty", qyd.size(), 0);
        chk("q_res_empty", qres.size(), 0);
        chk("q_done_empty", qdone.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
